// File: rtl/mem_arbiter_if.sv
// Bus bundle between the arbiter, the fetch/data requesters and the unified memory.
// Signals:
//   halt                                    - no new fetch grants while high
//   if_req/if_addr -> if_rdata/if_done/if_stall
//                                           - fetch read port
//   dm_rd/dm_wr/dm_addr/dm_wdata -> dm_rdata/dm_done/dm_stall
//                                           - data read/write port
//   mem_req/mem_wr/mem_addr/mem_wdata <- mem_stall/mem_done/mem_rdata
//                                           - memory handshake
//   err                                     - sticky error flag
// Modports:
//   master - the arbiter: serves the requesters and drives the memory request
//   slave  - the environment: requesters plus the memory
interface mem_arbiter_if;
    logic        halt;
    logic        if_req;
    logic [15:0] if_addr;
    logic [15:0] if_rdata;
    logic        if_done;
    logic        if_stall;
    logic        dm_rd;
    logic        dm_wr;
    logic [15:0] dm_addr;
    logic [15:0] dm_wdata;
    logic [15:0] dm_rdata;
    logic        dm_done;
    logic        dm_stall;
    logic        mem_req;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_stall;
    logic        mem_done;
    logic [15:0] mem_rdata;
    logic        err;

    modport master (
        input  halt, if_req, if_addr, dm_rd, dm_wr, dm_addr, dm_wdata,
        input  mem_stall, mem_done, mem_rdata,
        output if_rdata, if_done, if_stall, dm_rdata, dm_done, dm_stall,
        output mem_req, mem_wr, mem_addr, mem_wdata, err
    );

    modport slave (
        output halt, if_req, if_addr, dm_rd, dm_wr, dm_addr, dm_wdata,
        output mem_stall, mem_done, mem_rdata,
        input  if_rdata, if_done, if_stall, dm_rdata, dm_done, dm_stall,
        input  mem_req, mem_wr, mem_addr, mem_wdata, err
    );
endinterface

// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-ported, multi-cycle memory between instruction fetch (read-only)
// and the data stage (read/write). One access at a time; data has priority, but a waiting
// fetch is forced through after STARVE_MAX consecutive data grants. A watchdog aborts any
// access that stays in the request/wait phase for TIMEOUT cycles.
// Ports:
//   clk   - clock, all state on rising edge
//   rst_n - asynchronous active-low reset
//   bus   - mem_arbiter_if.master: requester ports, memory handshake, halt, err
module mem_arbiter #(
    parameter int unsigned STARVE_MAX = 4,
    parameter int unsigned TIMEOUT    = 32  // 2..255
) (
    input logic           clk,
    input logic           rst_n,
    mem_arbiter_if.master bus
);
    localparam logic [7:0] StarveMax = 8'(STARVE_MAX);
    localparam logic [7:0] Timeout   = 8'(TIMEOUT);

    typedef enum logic [2:0] {StIdle, StReqI, StReqD, StWaitI, StWaitD} state_e;

    state_e      state_q, state_d;
    logic [7:0]  starve_cnt_q, starve_cnt_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_wr_q, mem_wr_d;
    logic [15:0] mem_addr_q, mem_addr_d;
    logic [15:0] mem_wdata_q, mem_wdata_d;
    logic        if_done_q, if_done_d;
    logic [15:0] if_rdata_q, if_rdata_d;
    logic        dm_done_q, dm_done_d;
    logic [15:0] dm_rdata_q, dm_rdata_d;
    logic        err_q, err_d;

    logic dpend, ipend, turnaround;

    assign dpend = bus.dm_rd | bus.dm_wr;
    assign ipend = bus.if_req & ~bus.halt;
    // A cycle carrying a done pulse grants nothing: the finishing requester's request is
    // stale, and letting the other side in here would bypass data priority every time.
    assign turnaround = if_done_q | dm_done_q;

    always_comb begin
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
        wait_cnt_d   = wait_cnt_q;
        mem_req_d    = mem_req_q;
        mem_wr_d     = mem_wr_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        if_done_d    = 1'b0;
        if_rdata_d   = if_rdata_q;
        dm_done_d    = 1'b0;
        dm_rdata_d   = dm_rdata_q;
        err_d        = err_q;

        unique case (state_q)
            StIdle: begin
                if (!turnaround) begin
                    if (dpend && !(ipend && starve_cnt_q == StarveMax)) begin
                        state_d     = StReqD;
                        mem_req_d   = 1'b1;
                        mem_wr_d    = bus.dm_wr;  // rd&wr together is treated as a write
                        mem_addr_d  = bus.dm_addr;
                        mem_wdata_d = bus.dm_wdata;
                        wait_cnt_d  = 8'd0;
                        if (!ipend) begin
                            starve_cnt_d = 8'd0;
                        end else if (starve_cnt_q != StarveMax) begin
                            starve_cnt_d = starve_cnt_q + 8'd1;
                        end
                        if (bus.dm_rd && bus.dm_wr) begin
                            err_d = 1'b1;
                        end
                    end else if (ipend) begin
                        state_d      = StReqI;
                        mem_req_d    = 1'b1;
                        mem_wr_d     = 1'b0;
                        mem_addr_d   = bus.if_addr;
                        wait_cnt_d   = 8'd0;
                        starve_cnt_d = 8'd0;
                    end
                end
            end
            StReqI, StReqD, StWaitI, StWaitD: begin
                wait_cnt_d = wait_cnt_q + 8'd1;
                if ((state_q == StWaitI || state_q == StWaitD) && bus.mem_done) begin
                    state_d = StIdle;
                    if (state_q == StWaitI) begin
                        if_done_d  = 1'b1;
                        if_rdata_d = bus.mem_rdata;
                    end else begin
                        dm_done_d  = 1'b1;
                        dm_rdata_d = mem_wr_q ? 16'h0000 : bus.mem_rdata;
                    end
                end else if (wait_cnt_d == Timeout) begin
                    // Watchdog abort: complete the requester with zero data and flag it.
                    state_d   = StIdle;
                    mem_req_d = 1'b0;
                    err_d     = 1'b1;
                    if (state_q == StReqI || state_q == StWaitI) begin
                        if_done_d  = 1'b1;
                        if_rdata_d = 16'h0000;
                    end else begin
                        dm_done_d  = 1'b1;
                        dm_rdata_d = 16'h0000;
                    end
                end else if ((state_q == StReqI || state_q == StReqD) && !bus.mem_stall) begin
                    mem_req_d = 1'b0;
                    state_d   = (state_q == StReqI) ? StWaitI : StWaitD;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            starve_cnt_q <= 8'd0;
            wait_cnt_q   <= 8'd0;
            mem_req_q    <= 1'b0;
            mem_wr_q     <= 1'b0;
            mem_addr_q   <= 16'h0000;
            mem_wdata_q  <= 16'h0000;
            if_done_q    <= 1'b0;
            if_rdata_q   <= 16'h0000;
            dm_done_q    <= 1'b0;
            dm_rdata_q   <= 16'h0000;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            wait_cnt_q   <= wait_cnt_d;
            mem_req_q    <= mem_req_d;
            mem_wr_q     <= mem_wr_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            if_done_q    <= if_done_d;
            if_rdata_q   <= if_rdata_d;
            dm_done_q    <= dm_done_d;
            dm_rdata_q   <= dm_rdata_d;
            err_q        <= err_d;
        end
    end

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_wr    = mem_wr_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.if_done   = if_done_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.dm_done   = dm_done_q;
    assign bus.dm_rdata  = dm_rdata_q;
    assign bus.err       = err_q;
    assign bus.if_stall  = bus.if_req & ~if_done_q;
    assign bus.dm_stall  = (bus.dm_rd | bus.dm_wr) & ~dm_done_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter (STARVE_MAX=4, TIMEOUT=32). A small memory responder
// with configurable stall/latency logs every accepted request; scenario tasks drive the
// requesters and compare against hand-computed values.
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mem_arbiter_if bus ();

    mem_arbiter #(
        .STARVE_MAX(4),
        .TIMEOUT   (32)
    ) u_dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Memory responder configuration and observations
    bit          mem_en;
    int          cfg_stall;
    int          cfg_lat;
    logic [15:0] cfg_rdata;
    logic [15:0] acc_addr_q[$];
    logic [15:0] acc_wdata_q[$];
    logic        acc_wr_q[$];
    int          req_len;
    int          last_req_len;
    bit          req_stable;
    bit          last_stable;
    logic [15:0] first_addr;
    logic [15:0] first_wdata;
    logic        first_wr;
    int          stall_cnt;
    bit          busy;
    int          lat_left;

    initial begin
        bus.mem_stall = 1'b0;
        bus.mem_done  = 1'b0;
        bus.mem_rdata = 16'h0000;
        busy = 0; stall_cnt = 0; req_len = 0; lat_left = 0;
        last_req_len = 0; last_stable = 0; req_stable = 0;
        forever begin
            @(posedge clk);
            #1;
            bus.mem_done = 1'b0;
            if (!rst_n) begin
                busy = 0; stall_cnt = 0; req_len = 0;
                bus.mem_stall = 1'b0;
            end else begin
                if (busy) begin
                    lat_left--;
                    if (lat_left == 0) begin
                        busy = 0;
                        bus.mem_done  = 1'b1;
                        bus.mem_rdata = cfg_rdata;
                    end
                end
                if (bus.mem_req) begin
                    if (req_len == 0) begin
                        first_addr = bus.mem_addr; first_wdata = bus.mem_wdata;
                        first_wr = bus.mem_wr; req_stable = 1;
                    end else if (bus.mem_addr !== first_addr || bus.mem_wdata !== first_wdata ||
                                 bus.mem_wr !== first_wr) begin
                        req_stable = 0;
                    end
                    req_len++;
                    if (stall_cnt < cfg_stall) begin
                        bus.mem_stall = 1'b1;
                        stall_cnt++;
                    end else begin
                        bus.mem_stall = 1'b0;
                        stall_cnt = 0;
                        acc_addr_q.push_back(bus.mem_addr);
                        acc_wdata_q.push_back(bus.mem_wdata);
                        acc_wr_q.push_back(bus.mem_wr);
                        last_req_len = req_len;
                        last_stable  = req_stable;
                        req_len = 0;
                        if (mem_en) begin
                            busy = 1;
                            lat_left = cfg_lat;
                        end
                    end
                end else begin
                    bus.mem_stall = 1'b0;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish want finish before 200000");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_log();
        acc_addr_q.delete();
        acc_wdata_q.delete();
        acc_wr_q.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.halt = 0; bus.if_req = 0; bus.if_addr = 0;
        bus.dm_rd = 0; bus.dm_wr = 0; bus.dm_addr = 0; bus.dm_wdata = 0;
        mem_en = 1; cfg_stall = 0; cfg_lat = 1; cfg_rdata = 16'h0000;
        repeat (3) tick();
        checks++;
        if (bus.mem_req !== 1'b0 || bus.mem_wr !== 1'b0) begin
            failures++;
            $display("FAIL reset_mem_req: got req=%b wr=%b want 0 0", bus.mem_req, bus.mem_wr);
        end
        checks++;
        if (bus.mem_addr !== 16'h0 || bus.mem_wdata !== 16'h0) begin
            failures++;
            $display("FAIL reset_mem_bus: got %h/%h want 0000/0000", bus.mem_addr, bus.mem_wdata);
        end
        checks++;
        if (bus.if_done !== 1'b0 || bus.dm_done !== 1'b0 || bus.err !== 1'b0) begin
            failures++;
            $display("FAIL reset_flags: got if_done=%b dm_done=%b err=%b want 0 0 0",
                     bus.if_done, bus.dm_done, bus.err);
        end
        checks++;
        if (bus.if_rdata !== 16'h0 || bus.dm_rdata !== 16'h0) begin
            failures++;
            $display("FAIL reset_rdata: got %h/%h want 0000/0000", bus.if_rdata, bus.dm_rdata);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_lone_fetch();
        int  n = 0;
        bit  done = 0;
        bit  stall_ok = 1;
        clear_log();
        cfg_stall = 0; cfg_lat = 2; cfg_rdata = 16'hA5A5;
        bus.if_addr = 16'h0010;
        bus.if_req  = 1'b1;
        while (!done && n < 20) begin
            tick();
            n++;
            if (bus.if_done) done = 1;
            else if (bus.if_stall !== 1'b1) stall_ok = 0;
        end
        checks++;
        if (!done || n != 4) begin
            failures++;
            $display("FAIL fetch_latency: got done=%0d after %0d cycles want 1 after 4", done, n);
        end
        checks++;
        if (bus.if_rdata !== 16'hA5A5) begin
            failures++;
            $display("FAIL fetch_rdata: got %h want a5a5", bus.if_rdata);
        end
        checks++;
        if (!stall_ok) begin
            failures++;
            $display("FAIL fetch_stall: got if_stall low before if_done want high");
        end
        checks++;
        if (acc_addr_q.size() != 1 || acc_addr_q[0] !== 16'h0010 || acc_wr_q[0] !== 1'b0) begin
            failures++;
            $display("FAIL fetch_mem_req: got %0d accesses want one read of 0010",
                     acc_addr_q.size());
        end
        bus.if_req = 1'b0;
        tick();
        checks++;
        if (bus.if_done !== 1'b0 || bus.if_stall !== 1'b0) begin
            failures++;
            $display("FAIL fetch_pulse: got if_done=%b if_stall=%b want 0 0",
                     bus.if_done, bus.if_stall);
        end
    endtask

    task automatic test_priority();
        int          n = 0;
        bit          got_d = 0;
        bit          got_i = 0;
        logic [15:0] d_val = 16'h0;
        clear_log();
        cfg_lat = 1; cfg_rdata = 16'h3C3C;
        bus.if_addr = 16'h0020; bus.dm_addr = 16'h0200;
        bus.if_req = 1'b1; bus.dm_rd = 1'b1;
        while (!got_i && n < 30) begin
            tick();
            n++;
            if (bus.dm_done) begin
                got_d = 1; d_val = bus.dm_rdata; bus.dm_rd = 1'b0;
            end
            if (bus.if_done) begin
                got_i = 1; bus.if_req = 1'b0;
            end
        end
        checks++;
        if (!got_d || d_val !== 16'h3C3C) begin
            failures++;
            $display("FAIL prio_data: got done=%0d rdata=%h want 1 3c3c", got_d, d_val);
        end
        checks++;
        if (!got_i || acc_addr_q.size() != 2 || acc_addr_q[0] !== 16'h0200 ||
            acc_addr_q[1] !== 16'h0020) begin
            failures++;
            $display("FAIL prio_order: got %0d grants first=%h want 2 grants 0200 then 0020",
                     acc_addr_q.size(), acc_addr_q.size() > 0 ? acc_addr_q[0] : 16'hxxxx);
        end
        tick();
    endtask

    task automatic test_starvation();
        logic [15:0] exp_addr[5];
        int          n = 0;
        bit          got = 0;
        exp_addr[0] = 16'h0300; exp_addr[1] = 16'h0301; exp_addr[2] = 16'h0302;
        exp_addr[3] = 16'h0303; exp_addr[4] = 16'h0030;
        clear_log();
        cfg_lat = 1;
        bus.if_addr = 16'h0030; bus.if_req = 1'b1;
        bus.dm_addr = 16'h0300; bus.dm_rd = 1'b1;
        while (!got && n < 200) begin
            tick();
            n++;
            if (bus.dm_done) bus.dm_addr = bus.dm_addr + 16'h1;
            if (bus.if_done) begin
                got = 1; bus.if_req = 1'b0; bus.dm_rd = 1'b0;
            end
        end
        checks++;
        if (!got || acc_addr_q.size() != 5) begin
            failures++;
            $display("FAIL starve_count: got done=%0d grants=%0d want 1 5", got,
                     acc_addr_q.size());
        end
        for (int i = 0; i < 5; i++) begin
            if (i < acc_addr_q.size()) begin
                checks++;
                if (acc_addr_q[i] !== exp_addr[i]) begin
                    failures++;
                    $display("FAIL starve_grant%0d: got %h want %h", i, acc_addr_q[i],
                             exp_addr[i]);
                end
            end
        end
        tick();
    endtask

    task automatic test_write_stall();
        int n = 0;
        bit done = 0;
        clear_log();
        cfg_stall = 3; cfg_lat = 1; cfg_rdata = 16'hFFFF;
        bus.dm_addr = 16'h0100; bus.dm_wdata = 16'h1234; bus.dm_wr = 1'b1;
        while (!done && n < 30) begin
            tick();
            n++;
            if (bus.dm_done) done = 1;
        end
        bus.dm_wr = 1'b0;
        checks++;
        if (!done || n != 6) begin
            failures++;
            $display("FAIL wr_latency: got done=%0d after %0d cycles want 1 after 6", done, n);
        end
        checks++;
        if (bus.dm_rdata !== 16'h0000) begin
            failures++;
            $display("FAIL wr_rdata: got %h want 0000", bus.dm_rdata);
        end
        checks++;
        if (last_req_len != 4 || !last_stable) begin
            failures++;
            $display("FAIL wr_req_hold: got %0d cycles stable=%0d want 4 cycles stable=1",
                     last_req_len, last_stable);
        end
        checks++;
        if (acc_addr_q.size() != 1 || acc_addr_q[0] !== 16'h0100 ||
            acc_wdata_q[0] !== 16'h1234 || acc_wr_q[0] !== 1'b1) begin
            failures++;
            $display("FAIL wr_bus: got %0d accesses want one write 0100<=1234",
                     acc_addr_q.size());
        end
        cfg_stall = 0;
        tick();
    endtask

    task automatic test_timeout();
        int n = 0;
        bit done = 0;
        bit early_err = 0;
        clear_log();
        mem_en = 0; cfg_rdata = 16'hEEEE;
        bus.dm_addr = 16'h0400; bus.dm_rd = 1'b1;
        while (!done && n < 60) begin
            tick();
            n++;
            if (bus.dm_done) done = 1;
            else if (bus.err) early_err = 1;
        end
        bus.dm_rd = 1'b0;
        checks++;
        if (!done || n != 33) begin
            failures++;
            $display("FAIL tmo_latency: got done=%0d after %0d cycles want 1 after 33", done, n);
        end
        checks++;
        if (bus.err !== 1'b1 || early_err) begin
            failures++;
            $display("FAIL tmo_err: got err=%b early=%0d want 1 0", bus.err, early_err);
        end
        checks++;
        if (bus.dm_rdata !== 16'h0000 || bus.mem_req !== 1'b0) begin
            failures++;
            $display("FAIL tmo_abort: got rdata=%h mem_req=%b want 0000 0", bus.dm_rdata,
                     bus.mem_req);
        end
        tick();
        mem_en = 1; cfg_rdata = 16'h5A5A;
        bus.dm_addr = 16'h0401; bus.dm_rd = 1'b1;
        n = 0; done = 0;
        while (!done && n < 30) begin
            tick();
            n++;
            if (bus.dm_done) done = 1;
        end
        bus.dm_rd = 1'b0;
        checks++;
        if (!done || bus.dm_rdata !== 16'h5A5A || bus.err !== 1'b1) begin
            failures++;
            $display("FAIL tmo_recover: got done=%0d rdata=%h err=%b want 1 5a5a 1", done,
                     bus.dm_rdata, bus.err);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        int n = 0;
        bit replay = 0;
        clear_log();
        cfg_lat = 10; cfg_rdata = 16'h9999;
        bus.dm_addr = 16'h0500; bus.dm_rd = 1'b1;
        while (acc_addr_q.size() == 0 && n < 10) begin
            tick();
            n++;
        end
        tick();  // now in the wait phase
        #1;
        rst_n = 1'b0;
        bus.dm_rd = 1'b0;
        #1;
        checks++;
        if (bus.mem_req !== 1'b0 || bus.mem_addr !== 16'h0 || bus.mem_wr !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_mem: got req=%b addr=%h wr=%b want 0 0000 0", bus.mem_req,
                     bus.mem_addr, bus.mem_wr);
        end
        checks++;
        if (bus.dm_done !== 1'b0 || bus.if_done !== 1'b0 || bus.err !== 1'b0 ||
            bus.dm_rdata !== 16'h0 || bus.dm_stall !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_out: got dm_done=%b if_done=%b err=%b rdata=%h want all 0",
                     bus.dm_done, bus.if_done, bus.err, bus.dm_rdata);
        end
        repeat (2) tick();
        rst_n = 1'b1;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (bus.mem_req || bus.dm_done) replay = 1;
        end
        checks++;
        if (replay) begin
            failures++;
            $display("FAIL rst_mid_replay: got activity after reset want none");
        end
        cfg_lat = 1;
    endtask

    task automatic test_conflict();
        int n = 0;
        bit done = 0;
        clear_log();
        cfg_rdata = 16'h7777;
        bus.dm_addr = 16'h0600; bus.dm_wdata = 16'hBEEF;
        bus.dm_rd = 1'b1; bus.dm_wr = 1'b1;
        while (!done && n < 30) begin
            tick();
            n++;
            if (bus.dm_done) done = 1;
        end
        bus.dm_rd = 1'b0; bus.dm_wr = 1'b0;
        checks++;
        if (!done || bus.err !== 1'b1 || bus.dm_rdata !== 16'h0000) begin
            failures++;
            $display("FAIL conflict: got done=%0d err=%b rdata=%h want 1 1 0000", done, bus.err,
                     bus.dm_rdata);
        end
        checks++;
        if (acc_wr_q.size() != 1 || acc_wr_q[0] !== 1'b1 || acc_wdata_q[0] !== 16'hBEEF) begin
            failures++;
            $display("FAIL conflict_write: got %0d accesses want one write of beef",
                     acc_wr_q.size());
        end
        tick();
    endtask

    task automatic test_halt();
        int n = 0;
        bit blocked = 1;
        bit done = 0;
        clear_log();
        cfg_rdata = 16'h4242;
        bus.halt = 1'b1;
        bus.if_addr = 16'h0070; bus.if_req = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus.mem_req) blocked = 0;
        end
        checks++;
        if (!blocked || bus.if_stall !== 1'b1) begin
            failures++;
            $display("FAIL halt_block: got blocked=%0d if_stall=%b want 1 1", blocked,
                     bus.if_stall);
        end
        bus.dm_addr = 16'h0700; bus.dm_rd = 1'b1;
        while (!done && n < 30) begin
            tick();
            n++;
            if (bus.dm_done) done = 1;
        end
        bus.dm_rd = 1'b0;
        checks++;
        if (!done || bus.dm_rdata !== 16'h4242) begin
            failures++;
            $display("FAIL halt_data: got done=%0d rdata=%h want 1 4242", done, bus.dm_rdata);
        end
        repeat (5) tick();
        checks++;
        if (acc_addr_q.size() != 1) begin
            failures++;
            $display("FAIL halt_fetch_held: got %0d grants want 1", acc_addr_q.size());
        end
        bus.halt = 1'b0;
        n = 0; done = 0;
        while (!done && n < 30) begin
            tick();
            n++;
            if (bus.if_done) done = 1;
        end
        bus.if_req = 1'b0;
        checks++;
        if (!done || bus.if_rdata !== 16'h4242 || acc_addr_q.size() != 2 ||
            acc_addr_q[1] !== 16'h0070) begin
            failures++;
            $display("FAIL halt_release: got done=%0d rdata=%h grants=%0d want 1 4242 2", done,
                     bus.if_rdata, acc_addr_q.size());
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_lone_fetch();
        test_priority();
        test_starvation();
        test_write_stall();
        test_timeout();
        test_reset_mid();
        test_conflict();
        test_halt();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
